// File: rtl/encrypt_stream_sequencer.sv
// Message buffer and sequencer that walks stored ASCII text through the external
// Caesar-shift datapath and streams the encrypted characters over valid/ready.
module encrypt_stream_sequencer #(
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int MAX_SHIFT = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          clear,
    input  logic          start,
    input  logic [7:0]    shift_in,
    output logic [7:0]    enc_ascii_in,
    output logic [7:0]    enc_shift,
    input  logic [7:0]    enc_ascii_out,
    output logic          out_valid,
    output logic [7:0]    out_data,
    output logic          out_last,
    input  logic          out_ready,
    output logic          busy,
    output logic          done,
    output logic          shift_err,
    output logic          wr_overflow,
    output logic [AW:0]   msg_count
);

    localparam logic [AW:0] FULL_CNT    = (AW+1)'(DEPTH);
    localparam logic [7:0]  MAX_SHIFT_C = 8'(MAX_SHIFT);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PRESENT, S_DONE} state_t;

    state_t        state_q;
    logic [7:0]    mem [DEPTH];
    logic [AW:0]   msg_count_q;
    logic [AW-1:0] idx_q;
    logic [7:0]    shift_q;
    logic [7:0]    out_data_q;
    logic          done_q;
    logic          shift_err_q;
    logic          wr_overflow_q;

    logic          buf_full;
    logic          is_last;
    logic [AW:0]   last_idx;
    logic          mem_we;

    assign buf_full = (msg_count_q == FULL_CNT);
    assign last_idx = msg_count_q - (AW+1)'(1);
    assign is_last  = ({1'b0, idx_q} == last_idx);
    // start wins over clear and write; clear wins over write
    assign mem_we   = (state_q == S_IDLE) && wr_en && !start && !clear && !buf_full;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[msg_count_q[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            msg_count_q   <= '0;
            idx_q         <= '0;
            shift_q       <= '0;
            out_data_q    <= '0;
            done_q        <= 1'b0;
            shift_err_q   <= 1'b0;
            wr_overflow_q <= 1'b0;
        end else begin
            done_q        <= 1'b0;
            shift_err_q   <= 1'b0;
            wr_overflow_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (shift_in > MAX_SHIFT_C) begin
                            shift_err_q <= 1'b1;
                        end else if (msg_count_q == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            shift_q <= shift_in;
                            idx_q   <= '0;
                            state_q <= S_FETCH;
                        end
                    end else if (clear) begin
                        msg_count_q <= '0;
                    end else if (wr_en) begin
                        if (buf_full) begin
                            wr_overflow_q <= 1'b1;
                        end else begin
                            msg_count_q <= msg_count_q + (AW+1)'(1);
                        end
                    end
                end
                S_FETCH: begin
                    out_data_q <= enc_ascii_out;
                    state_q    <= S_PRESENT;
                end
                S_PRESENT: begin
                    if (out_ready) begin
                        if (is_last) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            idx_q   <= idx_q + AW'(1);
                            state_q <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign enc_ascii_in = (state_q == S_FETCH) ? mem[idx_q] : 8'h00;
    assign enc_shift    = shift_q;
    assign out_valid    = (state_q == S_PRESENT);
    assign out_last     = (state_q == S_PRESENT) && is_last;
    assign out_data     = out_data_q;
    assign busy         = (state_q == S_FETCH) || (state_q == S_PRESENT);
    assign done         = done_q;
    assign shift_err    = shift_err_q;
    assign wr_overflow  = wr_overflow_q;
    assign msg_count    = msg_count_q;

endmodule

// File: tb/tb_encrypt_stream_sequencer.sv
// Directed bench for encrypt_stream_sequencer with a behavioural Caesar datapath.
module tb_encrypt_stream_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       clear;
    logic       start;
    logic [7:0] shift_in;
    logic [7:0] enc_ascii_in;
    logic [7:0] enc_shift;
    logic [7:0] enc_ascii_out;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;
    logic       busy;
    logic       done;
    logic       shift_err;
    logic       wr_overflow;
    logic [4:0] msg_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    encrypt_stream_sequencer dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .clear(clear),
        .start(start), .shift_in(shift_in), .enc_ascii_in(enc_ascii_in),
        .enc_shift(enc_shift), .enc_ascii_out(enc_ascii_out), .out_valid(out_valid),
        .out_data(out_data), .out_last(out_last), .out_ready(out_ready), .busy(busy),
        .done(done), .shift_err(shift_err), .wr_overflow(wr_overflow), .msg_count(msg_count)
    );

    // Single-wrap Caesar datapath standing in for the real encryption block
    function automatic logic [7:0] caesar(input logic [7:0] c, input logic [7:0] s);
        logic [7:0] t;
        t = c + s;
        if (c >= 8'h41 && c <= 8'h5A) return (t > 8'h5A) ? t - 8'd26 : t;
        if (c >= 8'h61 && c <= 8'h7A) return (t > 8'h7A) ? t - 8'd26 : t;
        if (c >= 8'h30 && c <= 8'h39) return (t > 8'h39) ? t - 8'd10 : t;
        return c;
    endfunction

    assign enc_ascii_out = caesar(enc_ascii_in, enc_shift);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_char(input logic [7:0] c);
        wr_en = 1'b1; wr_data = c;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic start_run(input logic [7:0] s);
        start = 1'b1; shift_in = s;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        while (!out_valid && k < 10) begin
            tick();
            k++;
        end
    endtask

    task automatic load_msg();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        write_char(8'h41);
        write_char(8'h7A);
        write_char(8'h39);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (msg_count !== 5'd0) begin n_fail++; $display("FAIL reset_msg_count: got %0d expected 0", msg_count); end
        n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
        n_checks++; if ({done, shift_err, wr_overflow, out_last} !== 4'b0) begin n_fail++; $display("FAIL reset_pulses: got %b expected 0000", {done, shift_err, wr_overflow, out_last}); end
        n_checks++; if ({enc_ascii_in, enc_shift} !== 16'h0) begin n_fail++; $display("FAIL reset_enc: got %h expected 0000", {enc_ascii_in, enc_shift}); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] exp_c [3];
        int k;
        exp_c[0] = 8'h44; exp_c[1] = 8'h63; exp_c[2] = 8'h32;
        load_msg();
        n_checks++; if (msg_count !== 5'd3) begin n_fail++; $display("FAIL basic_count: got %0d expected 3", msg_count); end
        out_ready = 1'b1;
        start_run(8'd3);
        n_checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_fetch: got busy=%b valid=%b expected busy=1 valid=0", busy, out_valid); end
        n_checks++; if (enc_ascii_in !== 8'h41 || enc_shift !== 8'd3) begin n_fail++; $display("FAIL basic_enc_drive: got %h/%0d expected 41/3", enc_ascii_in, enc_shift); end
        for (int i = 0; i < 3; i++) begin
            wait_valid(k);
            n_checks++; if (k !== 1) begin n_fail++; $display("FAIL basic_latency[%0d]: got %0d cycles expected 1", i, k); end
            n_checks++; if (out_data !== exp_c[i]) begin n_fail++; $display("FAIL basic_data[%0d]: got %h expected %h", i, out_data, exp_c[i]); end
            n_checks++; if (out_last !== (i == 2)) begin n_fail++; $display("FAIL basic_last[%0d]: got %b expected %b", i, out_last, (i == 2)); end
            tick();
        end
        n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_done: got done=%b busy=%b expected done=1 busy=0", done, busy); end
        tick();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
        n_checks++; if (msg_count !== 5'd3) begin n_fail++; $display("FAIL basic_count_kept: got %0d expected 3", msg_count); end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_c [3];
        int k;
        int bad;
        exp_c[0] = 8'h44; exp_c[1] = 8'h63; exp_c[2] = 8'h32;
        out_ready = 1'b0;
        start_run(8'd3);
        for (int i = 0; i < 3; i++) begin
            wait_valid(k);
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_timeout[%0d]: got valid=%b expected 1", i, out_valid); end
            n_checks++; if (out_data !== exp_c[i] || out_last !== (i == 2)) begin n_fail++; $display("FAIL bp_data[%0d]: got %h last=%b expected %h last=%b", i, out_data, out_last, exp_c[i], (i == 2)); end
            if (i == 1) begin
                bad = 0;
                for (int j = 0; j < 5; j++) begin
                    tick();
                    if (out_valid !== 1'b1 || out_data !== 8'h63 || busy !== 1'b1) bad++;
                end
                n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL bp_hold: got %0d bad cycles expected 0", bad); end
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL bp_done: got %b expected 1", done); end
        tick();
    endtask

    task automatic test_shift_err();
        start_run(8'd10);
        n_checks++; if (shift_err !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL shift_err_pulse: got err=%b busy=%b valid=%b expected 1/0/0", shift_err, busy, out_valid); end
        tick();
        n_checks++; if (shift_err !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL shift_err_after: got err=%b busy=%b valid=%b expected 0/0/0", shift_err, busy, out_valid); end
    endtask

    task automatic test_start_priority();
        wr_en = 1'b1; wr_data = 8'h58;
        start_run(8'd10);
        wr_en = 1'b0;
        n_checks++; if (shift_err !== 1'b1 || msg_count !== 5'd3) begin n_fail++; $display("FAIL prio_start: got err=%b count=%0d expected 1/3", shift_err, msg_count); end
        tick();
    endtask

    task automatic test_empty_start();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_checks++; if (msg_count !== 5'd0) begin n_fail++; $display("FAIL empty_clear: got %0d expected 0", msg_count); end
        start_run(8'd3);
        n_checks++; if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL empty_done: got done=%b valid=%b busy=%b expected 1/0/0", done, out_valid, busy); end
        tick();
        n_checks++; if (done !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL empty_after: got done=%b valid=%b expected 0/0", done, out_valid); end
    endtask

    task automatic test_overflow();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 17; i++) begin
            write_char(8'h61 + 8'(i));
            if (wr_overflow === 1'b1) pulses++;
            if (i == 15) begin
                n_checks++; if (msg_count !== 5'd16) begin n_fail++; $display("FAIL ovf_full: got %0d expected 16", msg_count); end
            end
        end
        n_checks++; if (wr_overflow !== 1'b1 || msg_count !== 5'd16) begin n_fail++; $display("FAIL ovf_pulse: got ovf=%b count=%0d expected 1/16", wr_overflow, msg_count); end
        tick();
        if (wr_overflow === 1'b1) pulses++;
        n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL ovf_once: got %0d pulses expected 1", pulses); end
    endtask

    task automatic test_reset_mid_run();
        int k;
        int dones;
        load_msg();
        out_ready = 1'b0;
        start_run(8'd3);
        wait_valid(k);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        wait_valid(k);
        n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h63) begin n_fail++; $display("FAIL rst_mid_setup: got valid=%b data=%h expected 1/63", out_valid, out_data); end
        reset = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || msg_count !== 5'd0) begin n_fail++; $display("FAIL rst_mid: got valid=%b busy=%b done=%b count=%0d expected 0/0/0/0", out_valid, busy, done, msg_count); end
        tick();
        reset = 1'b0;
        dones = 0;
        for (int j = 0; j < 4; j++) begin
            tick();
            if (done === 1'b1 || out_valid === 1'b1) dones++;
        end
        n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL rst_mid_quiet: got %0d active cycles expected 0", dones); end
    endtask

    task automatic test_reload();
        int k;
        write_char(8'h62);
        out_ready = 1'b1;
        start_run(8'd9);
        wait_valid(k);
        n_checks++; if (out_data !== 8'h6B || out_last !== 1'b1) begin n_fail++; $display("FAIL reload_data: got %h last=%b expected 6b last=1", out_data, out_last); end
        tick();
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL reload_done: got %b expected 1", done); end
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; clear = 1'b0;
        start = 1'b0; shift_in = 8'h00; out_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_start_priority();
        test_shift_err();
        test_empty_start();
        test_overflow();
        test_reset_mid_run();
        test_reload();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
